// File: rtl/shift_frame_feeder.sv
// Parallel-to-serial frame feeder: takes one DEPTH-word frame over valid/ready and
// emits it one word per cycle with a shift strobe, stallable by the consumer.
module shift_frame_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_load_valid,
    output logic                     io_load_ready,
    input  logic [WIDTH*DEPTH-1:0]   io_frame,
    input  logic                     io_hold,
    output logic                     io_shift,
    output logic [WIDTH-1:0]         io_word,
    output logic                     io_done,
    output logic                     io_busy
);

    localparam int FRAME_W = WIDTH * DEPTH;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]     word_q, word_d;
    logic                 accept;
    logic                 advance;
    logic                 last;

    function automatic logic [WIDTH-1:0] word_at(input logic [FRAME_W-1:0] f,
                                                 input logic [IDX_W-1:0]   i);
        return f[int'(i)*WIDTH +: WIDTH];
    endfunction

    assign accept  = io_load_valid && io_load_ready;
    assign advance = (state_q == SHIFT) && !io_hold;
    assign last    = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (advance && last) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        io_load_ready = 1'b0;
        io_busy       = 1'b0;
        io_shift      = 1'b0;
        io_done       = 1'b0;
        case (state_q)
            IDLE:  io_load_ready = reset;
            SHIFT: begin
                io_busy  = 1'b1;
                io_shift = !io_hold;
            end
            DONE: begin
                io_done       = 1'b1;
                io_load_ready = reset;
            end
            default: ;
        endcase
    end

    // The word register is preloaded with the next word so io_word never depends on io_frame directly.
    always_comb begin
        idx_d  = idx_q;
        buf_d  = buf_q;
        word_d = word_q;
        if (accept) begin
            buf_d  = io_frame;
            idx_d  = '0;
            word_d = word_at(io_frame, '0);
        end else if (advance) begin
            if (last) begin
                idx_d = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                word_d = word_at(buf_q, idx_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q  <= '0;
            buf_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            buf_q  <= buf_d;
            word_q <= word_d;
        end
    end

    assign io_word = word_q;

endmodule

// File: tb/tb_shift_frame_feeder.sv
// Directed and randomized bench for shift_frame_feeder (DEPTH=4 and DEPTH=1 instances)
// against a frame-level reference: word i of a frame is (frame >> 4*i) & 4'hF.
module tb_shift_frame_feeder;

    localparam int W = 4;
    localparam int D = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           lv, lr, hold, sh, done, busy;
    logic [W*D-1:0] frame;
    logic [W-1:0]   word;

    logic           d1_lv, d1_lr, d1_hold, d1_sh, d1_done, d1_busy;
    logic [W-1:0]   d1_frame;
    logic [W-1:0]   d1_word;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    shift_frame_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .io_load_valid(lv), .io_load_ready(lr), .io_frame(frame),
        .io_hold(hold), .io_shift(sh), .io_word(word),
        .io_done(done), .io_busy(busy)
    );

    shift_frame_feeder #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clock(clock), .reset(reset),
        .io_load_valid(d1_lv), .io_load_ready(d1_lr), .io_frame(d1_frame),
        .io_hold(d1_hold), .io_shift(d1_sh), .io_word(d1_word),
        .io_done(d1_done), .io_busy(d1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] wref(input logic [15:0] f, input int i);
        return 4'((f >> (4 * i)) & 16'h000F);
    endfunction

    task automatic accept_idle(input logic [15:0] f);
        step();
        lv = 1'b1; frame = f; hold = 1'($urandom_range(0, 1));
        settle();
        chk("idle_ready", lr, 1);
        chk("idle_busy", busy, 0);
        chk("idle_shift", sh, 0);
        chk("idle_done", done, 0);
    endtask

    task automatic idle_cycle();
        step();
        lv = 1'b0; hold = 1'($urandom_range(0, 1));
        settle();
        chk("idle_ready", lr, 1);
        chk("idle_busy", busy, 0);
        chk("idle_shift", sh, 0);
        chk("idle_done", done, 0);
    endtask

    // mask bit c = hold during the c-th cycle after accept; load_c = cycle with a stray load attempt
    task automatic shift_phase(input logic [15:0] f, input logic [31:0] mask,
                               input bit rnd, input int load_c);
        int i = 0;
        int c = 0;
        while (i < D) begin
            step();
            if (rnd) begin
                hold  = (c < 40) && ($urandom_range(0, 2) == 0);
                lv    = 1'($urandom_range(0, 1));
                frame = 16'($urandom);
            end else begin
                hold = (c < 32) ? mask[c] : 1'b0;
                lv   = (c == load_c);
                if (c == load_c) frame = 16'hFFFF;
            end
            settle();
            chk("shift_busy", busy, 1);
            chk("shift_ready", lr, 0);
            chk("shift_done", done, 0);
            chk("shift_strobe", sh, !hold);
            chk("shift_word", word, wref(f, i));
            if (!hold) i++;
            c++;
        end
    endtask

    task automatic done_phase(input logic [15:0] f, input bit nv, input logic [15:0] nf);
        step();
        lv = nv; frame = nf; hold = 1'($urandom_range(0, 1));
        settle();
        chk("done_pulse", done, 1);
        chk("done_shift", sh, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", lr, 1);
        chk("done_word", word, wref(f, D - 1));
    endtask

    initial begin
        logic [15:0] f;
        logic [15:0] nf;
        bit          nv;
        logic [3:0]  d1_seq [3];

        reset = 1'b0; lv = 1'b0; frame = '0; hold = 1'b0;
        d1_lv = 1'b0; d1_frame = '0; d1_hold = 1'b0;

        step();
        chk("rst_shift", sh, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word", word, 0);
        chk("rst_ready", lr, 0);
        step();
        reset = 1'b1;
        settle();
        chk("post_rst_ready", lr, 1);
        chk("post_rst_busy", busy, 0);

        // basic frame
        accept_idle(16'h4321);
        shift_phase(16'h4321, 32'h0, 1'b0, -1);
        done_phase(16'h4321, 1'b0, 16'h0);
        idle_cycle();

        // hold in cycles 2-3
        accept_idle(16'h4321);
        shift_phase(16'h4321, 32'b0110, 1'b0, -1);
        done_phase(16'h4321, 1'b0, 16'h0);
        idle_cycle();

        // back-to-back frames
        accept_idle(16'h4321);
        shift_phase(16'h4321, 32'h0, 1'b0, -1);
        done_phase(16'h4321, 1'b1, 16'h8765);
        shift_phase(16'h8765, 32'h0, 1'b0, -1);
        done_phase(16'h8765, 1'b0, 16'h0);
        idle_cycle();

        // stray load during SHIFT
        accept_idle(16'h4321);
        shift_phase(16'h4321, 32'h0, 1'b0, 1);
        done_phase(16'h4321, 1'b0, 16'h0);
        idle_cycle();

        // hold on the last word delays DONE
        accept_idle(16'hB9E2);
        shift_phase(16'hB9E2, 32'b11000, 1'b0, -1);
        done_phase(16'hB9E2, 1'b0, 16'h0);
        idle_cycle();

        // reset mid-frame
        accept_idle(16'h4321);
        step();
        lv = 1'b0; hold = 1'b0;
        settle();
        chk("mid_word0", word, 4'h1);
        chk("mid_shift", sh, 1);
        step();
        reset = 1'b0;
        settle();
        chk("mid_rst_ready", lr, 0);
        step();
        reset = 1'b1;
        settle();
        chk("abort_shift", sh, 0);
        chk("abort_word", word, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", lr, 1);
        for (int k = 0; k < 3; k++) idle_cycle();
        accept_idle(16'h8765);
        shift_phase(16'h8765, 32'h0, 1'b0, -1);
        done_phase(16'h8765, 1'b0, 16'h0);
        idle_cycle();

        // randomized frames, holds, stray loads and back-to-back accepts
        f = 16'($urandom);
        accept_idle(f);
        for (int k = 0; k < 20; k++) begin
            shift_phase(f, 32'h0, 1'b1, -1);
            nv = (k < 19) && ($urandom_range(0, 1) == 1);
            nf = 16'($urandom);
            done_phase(f, nv, nf);
            if (nv) begin
                f = nf;
            end else if (k < 19) begin
                idle_cycle();
                f = 16'($urandom);
                accept_idle(f);
            end
        end
        idle_cycle();

        // DEPTH=1 instance: three frames back-to-back, one hold
        d1_seq[0] = 4'hA; d1_seq[1] = 4'h5; d1_seq[2] = 4'hC;
        step();
        d1_lv = 1'b1; d1_frame = d1_seq[0];
        settle();
        chk("d1_ready", d1_lr, 1);
        chk("d1_idle_busy", d1_busy, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                step();
                d1_lv = 1'b0; d1_hold = 1'b1;
                settle();
                chk("d1_hold_shift", d1_sh, 0);
                chk("d1_hold_word", d1_word, d1_seq[k]);
                chk("d1_hold_busy", d1_busy, 1);
            end
            step();
            d1_lv = 1'b0; d1_hold = 1'b0;
            settle();
            chk("d1_shift", d1_sh, 1);
            chk("d1_word", d1_word, d1_seq[k]);
            chk("d1_busy", d1_busy, 1);
            chk("d1_nodone", d1_done, 0);
            step();
            d1_lv = (k < 2);
            d1_frame = (k < 2) ? d1_seq[k + 1] : 4'h0;
            settle();
            chk("d1_done", d1_done, 1);
            chk("d1_done_shift", d1_sh, 0);
            chk("d1_done_word", d1_word, d1_seq[k]);
            chk("d1_done_ready", d1_lr, 1);
        end
        step();
        d1_lv = 1'b0;
        settle();
        chk("d1_final_done", d1_done, 0);
        chk("d1_final_busy", d1_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
